// File: rtl/nac_axi_read_bridge_if.sv
// Request, forwarded-data and AXI4 read channel signals of the read bridge.
// master = bridge side, slave = requester / AXI slave / consumer side.
interface nac_axi_read_bridge_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic        req_grant;

    logic        rd_valid;
    logic [31:0] rd_data;

    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;

    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    modport master (
        input  req_valid, req_addr, req_len,
        output req_grant,
        output rd_valid, rd_data,
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output req_valid, req_addr, req_len,
        input  req_grant,
        input  rd_valid, rd_data,
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/nac_axi_read_bridge.sv
// Turns single-cycle burst requests into AXI4 INCR reads and forwards R beats to a no-backpressure consumer.
// Latency: req -> arvalid 2 cycles, AR handshake -> grant 1 cycle, R beat -> rd_valid 1 cycle; rready always high.
module nac_axi_read_bridge #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    nac_axi_read_bridge_if.master bus,
    output logic                  busy,
    output logic                  err
);
    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    logic        r_pend_vld;
    logic [31:0] r_pend_addr;
    logic [7:0]  r_pend_len;
    logic        r_arvalid;
    logic [31:0] r_araddr;
    logic [7:0]  r_arlen;
    logic        r_ar_drop;
    logic [3:0]  r_outstanding;
    logic [3:0]  r_discard;
    logic        r_grant;
    logic        r_rd_vld;
    logic [31:0] r_rd_data;
    logic        r_rready;
    logic        r_busy;
    logic        r_err;

    logic        w_ar_hs;
    logic        w_r_hs;
    logic        w_rlast_hs;
    logic        w_launch;
    logic        w_accept;
    logic        w_drop_err;
    logic        w_fwd;
    logic        w_pend_vld_nxt;
    logic        w_arvalid_nxt;
    logic [3:0]  w_out_nxt;
    logic [3:0]  w_disc_nxt;

    assign w_ar_hs    = r_arvalid & bus.m_axi_arready;
    assign w_r_hs     = bus.m_axi_rvalid & r_rready;
    assign w_rlast_hs = w_r_hs & bus.m_axi_rlast;
    assign w_launch   = r_pend_vld & ~r_arvalid & ~flush & (r_outstanding < MAX_OUT);
    assign w_accept   = bus.req_valid & ~flush & ~r_pend_vld & ~r_arvalid;
    assign w_drop_err = bus.req_valid & ~flush & (r_pend_vld | r_arvalid);
    assign w_fwd      = w_r_hs & ~flush & (r_discard == 4'd0);

    always_comb begin
        w_pend_vld_nxt = r_pend_vld;
        // flush also drops a request that has not yet reached the AR channel
        if (flush || w_launch) begin
            w_pend_vld_nxt = 1'b0;
        end else if (w_accept) begin
            w_pend_vld_nxt = 1'b1;
        end

        w_arvalid_nxt = w_launch | (r_arvalid & ~bus.m_axi_arready);

        w_out_nxt = r_outstanding;
        if (w_ar_hs && !w_rlast_hs) begin
            w_out_nxt = r_outstanding + 4'd1;
        end else if (!w_ar_hs && w_rlast_hs && (r_outstanding != 4'd0)) begin
            w_out_nxt = r_outstanding - 4'd1;
        end

        w_disc_nxt = r_discard;
        if (flush) begin
            w_disc_nxt = w_out_nxt;
        end else begin
            if (w_rlast_hs && (r_discard != 4'd0)) begin
                w_disc_nxt = w_disc_nxt - 4'd1;
            end
            // an AR that was stalled across a flush joins the discard set when it finally issues
            if (w_ar_hs && r_ar_drop) begin
                w_disc_nxt = w_disc_nxt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_vld    <= 1'b0;
            r_pend_addr   <= 32'd0;
            r_pend_len    <= 8'd0;
            r_arvalid     <= 1'b0;
            r_araddr      <= 32'd0;
            r_arlen       <= 8'd0;
            r_ar_drop     <= 1'b0;
            r_outstanding <= 4'd0;
            r_discard     <= 4'd0;
            r_grant       <= 1'b0;
            r_rd_vld      <= 1'b0;
            r_rd_data     <= 32'd0;
            r_rready      <= 1'b0;
            r_busy        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_rready   <= 1'b1;
            r_pend_vld <= w_pend_vld_nxt;
            if (w_accept) begin
                r_pend_addr <= bus.req_addr;
                r_pend_len  <= bus.req_len;
            end
            r_arvalid <= w_arvalid_nxt;
            if (w_launch) begin
                r_araddr <= r_pend_addr;
                r_arlen  <= r_pend_len;
            end
            if (w_ar_hs) begin
                r_ar_drop <= 1'b0;
            end else if (flush && r_arvalid) begin
                r_ar_drop <= 1'b1;
            end
            r_grant       <= w_ar_hs;
            r_outstanding <= w_out_nxt;
            r_discard     <= w_disc_nxt;
            r_rd_vld      <= w_fwd;
            if (w_fwd) begin
                r_rd_data <= bus.m_axi_rdata;
            end
            r_busy <= w_pend_vld_nxt | w_arvalid_nxt | (w_out_nxt != 4'd0);
            if (w_drop_err || (w_r_hs && (bus.m_axi_rresp != 2'b00))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.req_grant     = r_grant;
    assign bus.rd_valid      = r_rd_vld;
    assign bus.rd_data       = r_rd_data;
    assign bus.m_axi_araddr  = r_araddr;
    assign bus.m_axi_arlen   = r_arlen;
    assign bus.m_axi_arsize  = 3'b010;
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arvalid = r_arvalid;
    assign bus.m_axi_rready  = r_rready;
    assign busy              = r_busy;
    assign err               = r_err;
endmodule

// File: tb/tb_nac_axi_read_bridge.sv
// Bench for nac_axi_read_bridge: directed scenarios with random addresses, lengths and data,
// scored against a burst-level model (bursts visible on AR at a flush are dropped, AXI returns in order).
module tb_nac_axi_read_bridge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy;
    logic err;

    nac_axi_read_bridge_if bus ();

    nac_axi_read_bridge #(.MAX_OUTSTANDING(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    int          ar_len_log[$];
    int          ar_cnt = 0;
    int          rl_cnt = 0;
    int          doom_upto = 0;
    int          n_fwd = 0;
    int          slv_idx = 0;
    int          slv_beat = 0;
    logic [31:0] mon_e;

    // Monitor / scoreboard, sampling mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            ar_len_log.delete();
            ar_cnt    = 0;
            rl_cnt    = 0;
            doom_upto = 0;
        end else begin
            if (bus.rd_valid) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_unexpected: got rd_valid data=%h, required no beat", bus.rd_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    n_fwd++;
                    if (bus.rd_data !== mon_e) begin
                        n_err++;
                        $display("FAIL rd_data: got %h, required %h", bus.rd_data, mon_e);
                    end
                end
            end
            if (flush) doom_upto = ar_cnt + (bus.m_axi_arvalid ? 1 : 0);
            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                ar_len_log.push_back(int'(bus.m_axi_arlen));
                ar_cnt++;
            end
            if (bus.m_axi_rvalid && bus.m_axi_rready) begin
                if (!flush && rl_cnt >= doom_upto) exp_q.push_back(bus.m_axi_rdata);
                if (bus.m_axi_rlast) rl_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [31:0] a, input logic [7:0] l);
        cyc();
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_len   = l;
        cyc();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_grant(input int lim, output int got);
        got = 0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (bus.req_grant) got++;
        end
        cyc();
    endtask

    task automatic wait_arvalid(input int lim, output bit saw);
        saw = 1'b0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (bus.m_axi_arvalid) begin
                saw = 1'b1;
                break;
            end
        end
        cyc();
    endtask

    task automatic drive_beat(input logic [1:0] resp);
        cyc();
        n_vec++;
        if (slv_idx >= ar_len_log.size()) begin
            n_err++;
            $display("FAIL slave_no_burst: %0d bursts issued, required burst index %0d", ar_len_log.size(), slv_idx);
            bus.m_axi_rvalid = 1'b0;
        end else begin
            bus.m_axi_rvalid = 1'b1;
            bus.m_axi_rdata  = $urandom;
            bus.m_axi_rresp  = resp;
            bus.m_axi_rlast  = (slv_beat == ar_len_log[slv_idx]);
            if (bus.m_axi_rlast) begin
                slv_idx++;
                slv_beat = 0;
            end else begin
                slv_beat++;
            end
        end
    endtask

    task automatic r_idle();
        cyc();
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
        bus.m_axi_rresp  = 2'b00;
    endtask

    task automatic send_beats(input int n);
        for (int i = 0; i < n; i++) drive_beat(2'b00);
        r_idle();
    endtask

    task automatic test_reset();
        bus.req_valid = 0; bus.req_addr = 0; bus.req_len = 0;
        bus.m_axi_arready = 0; bus.m_axi_rvalid = 0; bus.m_axi_rdata = 0;
        bus.m_axi_rresp = 0; bus.m_axi_rlast = 0;
        rst_n = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        n_vec++;
        if ({bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen, bus.m_axi_rready, bus.req_grant,
             bus.rd_valid, bus.rd_data, busy, err} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: arvalid=%b araddr=%h arlen=%h rready=%b grant=%b rd_valid=%b rd_data=%h busy=%b err=%b, required all 0",
                     bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen, bus.m_axi_rready, bus.req_grant,
                     bus.rd_valid, bus.rd_data, busy, err);
        end
        n_vec++;
        if ({bus.m_axi_arsize, bus.m_axi_arburst} !== 5'b010_01) begin
            n_err++;
            $display("FAIL reset_arsize_arburst: got %b/%b, required 010/01", bus.m_axi_arsize, bus.m_axi_arburst);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        @(negedge clk);
        n_vec++;
        if (bus.m_axi_rready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: rready=%b busy=%b, required rready=1 busy=0", bus.m_axi_rready, busy);
        end
    endtask

    task automatic test_single_burst();
        int f0;
        bus.m_axi_arready = 1'b1;
        f0 = n_fwd;
        cyc();
        bus.req_valid = 1'b1; bus.req_addr = 32'h1000; bus.req_len = 8'd15;
        cyc();
        bus.req_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.m_axi_arvalid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_n1: arvalid=%b busy=%b, required arvalid=0 busy=1", bus.m_axi_arvalid, busy);
        end
        cyc();
        @(negedge clk);
        n_vec++;
        if ({bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst, bus.req_grant}
            !== {1'b1, 32'h1000, 8'd15, 3'b010, 2'b01, 1'b0}) begin
            n_err++;
            $display("FAIL single_ar_n2: arvalid=%b araddr=%h arlen=%0d arsize=%b arburst=%b grant=%b, required 1 00001000 15 010 01 0",
                     bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst, bus.req_grant);
        end
        cyc();
        @(negedge clk);
        n_vec++;
        if (bus.req_grant !== 1'b1 || bus.m_axi_arvalid !== 1'b0) begin
            n_err++;
            $display("FAIL single_grant_n3: grant=%b arvalid=%b, required grant=1 arvalid=0", bus.req_grant, bus.m_axi_arvalid);
        end
        cyc();
        @(negedge clk);
        n_vec++;
        if (bus.req_grant !== 1'b0) begin
            n_err++;
            $display("FAIL single_grant_width: grant=%b at N+4, required 0", bus.req_grant);
        end
        send_beats(16);
        repeat (3) cyc();
        @(negedge clk);
        n_vec++;
        if (n_fwd - f0 != 16 || exp_q.size() != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_done: forwarded=%0d pending=%0d busy=%b, required 16 0 0", n_fwd - f0, exp_q.size(), busy);
        end
    endtask

    task automatic test_outstanding_limit();
        int lens[5];
        int got;
        int total = 0;
        int f0;
        f0 = n_fwd;
        for (int i = 0; i < 5; i++) lens[i] = $urandom_range(0, 3);
        for (int i = 0; i < 4; i++) begin
            send_req($urandom, 8'(lens[i]));
            wait_grant(10, got);
            n_vec++;
            if (got != 1) begin
                n_err++;
                $display("FAIL limit_grant%0d: %0d grants, required 1", i, got);
            end
        end
        send_req($urandom, 8'(lens[4]));
        wait_grant(12, got);
        @(negedge clk);
        n_vec++;
        if (got != 0 || bus.m_axi_arvalid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL limit_withheld: grants=%0d arvalid=%b busy=%b, required 0 0 1", got, bus.m_axi_arvalid, busy);
        end
        send_beats(lens[0] + 1);
        wait_grant(10, got);
        n_vec++;
        if (got != 1) begin
            n_err++;
            $display("FAIL limit_release: %0d grants after rlast, required 1", got);
        end
        for (int i = 0; i < 5; i++) total += lens[i] + 1;
        send_beats(total - (lens[0] + 1));
        repeat (3) cyc();
        n_vec++;
        if (n_fwd - f0 != total || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL limit_data: forwarded=%0d pending=%0d, required %0d 0", n_fwd - f0, exp_q.size(), total);
        end
    endtask

    task automatic test_flush_midstream();
        int got;
        int nl;
        int f0;
        f0 = n_fwd;
        nl = $urandom_range(0, 7);
        send_req(32'h0000_3000, 8'd15);
        wait_grant(10, got);
        send_req(32'h0000_4000, 8'd15);
        wait_grant(10, got);
        send_beats(3);
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        send_req(32'h0000_2000, 8'(nl));
        wait_grant(10, got);
        n_vec++;
        if (got != 1) begin
            n_err++;
            $display("FAIL flush_new_grant: %0d grants, required 1", got);
        end
        send_beats(29 + nl + 1);
        repeat (3) cyc();
        n_vec++;
        if (n_fwd - f0 != 3 + nl + 1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL flush_forwarded: forwarded=%0d pending=%0d, required %0d 0", n_fwd - f0, exp_q.size(), 3 + nl + 1);
        end
    endtask

    task automatic test_ar_stall_flush();
        int got;
        bit saw;
        int l;
        int l2;
        int f0;
        logic [31:0] a;
        a  = $urandom;
        l  = $urandom_range(0, 5);
        l2 = $urandom_range(0, 5);
        bus.m_axi_arready = 1'b0;
        send_req(a, 8'(l));
        wait_arvalid(6, saw);
        flush = 1'b1;
        cyc();
        cyc();
        flush = 1'b0;
        repeat (2) cyc();
        @(negedge clk);
        n_vec++;
        if (!saw || bus.m_axi_arvalid !== 1'b1 || bus.m_axi_araddr !== a || bus.m_axi_arlen !== 8'(l)) begin
            n_err++;
            $display("FAIL stall_hold: saw=%b arvalid=%b araddr=%h arlen=%0d, required 1 1 %h %0d",
                     saw, bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen, a, l);
        end
        cyc();
        bus.m_axi_arready = 1'b1;
        wait_grant(5, got);
        n_vec++;
        if (got != 1) begin
            n_err++;
            $display("FAIL stall_grant: %0d grants, required 1", got);
        end
        f0 = n_fwd;
        send_beats(l + 1);
        repeat (2) cyc();
        n_vec++;
        if (n_fwd != f0) begin
            n_err++;
            $display("FAIL stall_discard: forwarded=%0d, required 0", n_fwd - f0);
        end
        send_req($urandom, 8'(l2));
        wait_grant(10, got);
        send_beats(l2 + 1);
        repeat (3) cyc();
        n_vec++;
        if (n_fwd - f0 != l2 + 1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL stall_resume: forwarded=%0d pending=%0d, required %0d 0", n_fwd - f0, exp_q.size(), l2 + 1);
        end
    endtask

    task automatic test_error_paths();
        int got;
        int l;
        int f0;
        l = $urandom_range(1, 4);
        cyc();
        flush = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr = $urandom;
        bus.req_len = 8'd0;
        cyc();
        bus.req_valid = 1'b0;
        flush = 1'b0;
        wait_grant(8, got);
        @(negedge clk);
        n_vec++;
        if (got != 0 || err !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_req_silent: grants=%0d err=%b busy=%b, required 0 0 0", got, err, busy);
        end
        bus.m_axi_arready = 1'b0;
        send_req($urandom, 8'(l));
        send_req($urandom, 8'd3);
        @(negedge clk);
        n_vec++;
        if (err !== 1'b1) begin
            n_err++;
            $display("FAIL drop_err: err=%b, required 1", err);
        end
        cyc();
        bus.m_axi_arready = 1'b1;
        wait_grant(12, got);
        n_vec++;
        if (got != 1) begin
            n_err++;
            $display("FAIL drop_single_grant: %0d grants, required 1", got);
        end
        f0 = n_fwd;
        drive_beat(2'b10);
        send_beats(l);
        repeat (3) cyc();
        @(negedge clk);
        n_vec++;
        if (err !== 1'b1 || n_fwd - f0 != l + 1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rresp_err: err=%b forwarded=%0d pending=%0d, required 1 %0d 0", err, n_fwd - f0, exp_q.size(), l + 1);
        end
    endtask

    task automatic test_simultaneous();
        int got;
        bit saw;
        int r;
        r = $urandom_range(0, 3);
        send_req($urandom, 8'd1);
        wait_grant(10, got);
        send_req($urandom, 8'd1);
        wait_grant(10, got);
        @(negedge clk);
        n_vec++;
        if (dut.r_outstanding !== 4'd2) begin
            n_err++;
            $display("FAIL sim_pre: outstanding=%0d, required 2", dut.r_outstanding);
        end
        cyc();
        bus.m_axi_arready = 1'b0;
        send_req($urandom, 8'(r));
        wait_arvalid(6, saw);
        drive_beat(2'b00);
        drive_beat(2'b00);
        bus.m_axi_arready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (!saw || !(bus.m_axi_arvalid && bus.m_axi_rvalid && bus.m_axi_rlast)) begin
            n_err++;
            $display("FAIL sim_setup: saw=%b arvalid=%b rvalid=%b rlast=%b, required all 1",
                     saw, bus.m_axi_arvalid, bus.m_axi_rvalid, bus.m_axi_rlast);
        end
        r_idle();
        @(negedge clk);
        n_vec++;
        if (dut.r_outstanding !== 4'd2 || bus.req_grant !== 1'b1) begin
            n_err++;
            $display("FAIL sim_outstanding: outstanding=%0d grant=%b, required 2 1", dut.r_outstanding, bus.req_grant);
        end
        send_beats(2 + r + 1);
        repeat (3) cyc();
        @(negedge clk);
        n_vec++;
        if (dut.r_outstanding !== 4'd0 || exp_q.size() != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL sim_drain: outstanding=%0d pending=%0d busy=%b, required 0 0 0", dut.r_outstanding, exp_q.size(), busy);
        end
    endtask

    task automatic test_reset_midburst();
        int got;
        int l;
        int f0;
        send_req($urandom, 8'd7);
        wait_grant(10, got);
        drive_beat(2'b00);
        drive_beat(2'b00);
        drive_beat(2'b00);
        send_req($urandom, 8'd2);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen, bus.m_axi_rready, bus.req_grant,
             bus.rd_valid, bus.rd_data, busy, err} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: arvalid=%b araddr=%h arlen=%h rready=%b grant=%b rd_valid=%b rd_data=%h busy=%b err=%b, required all 0",
                     bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen, bus.m_axi_rready, bus.req_grant,
                     bus.rd_valid, bus.rd_data, busy, err);
        end
        n_vec++;
        if ({dut.r_pend_vld, dut.r_outstanding, dut.r_discard} !== 9'd0 ||
            {bus.m_axi_arsize, bus.m_axi_arburst} !== 5'b010_01) begin
            n_err++;
            $display("FAIL midreset_state: pend=%b outstanding=%0d discard=%0d arsize=%b arburst=%b, required 0 0 0 010 01",
                     dut.r_pend_vld, dut.r_outstanding, dut.r_discard, bus.m_axi_arsize, bus.m_axi_arburst);
        end
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
        slv_idx  = 0;
        slv_beat = 0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        l  = $urandom_range(0, 7);
        f0 = n_fwd;
        send_req($urandom, 8'(l));
        wait_grant(10, got);
        send_beats(l + 1);
        repeat (3) cyc();
        n_vec++;
        if (got != 1 || n_fwd - f0 != l + 1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL post_midreset: grants=%0d forwarded=%0d pending=%0d, required 1 %0d 0", got, n_fwd - f0, exp_q.size(), l + 1);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_outstanding_limit();
        test_flush_midstream();
        test_ar_stall_flush();
        test_error_paths();
        test_simultaneous();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/nac_axi_read_bridge.md
NAC_AXI_READ_BRIDGE -- requirements
Module: nac_axi_read_bridge

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4: maximum AXI read bursts in flight (range 1..15).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  high means the stream consumer is disabled; drop pending work and data.
REQ-005 req_valid  input  1  single-cycle burst request strobe.
REQ-006 req_addr  input  32  byte address of the burst; sampled with req_valid.
REQ-007 req_len  input  8  AXI-encoded beat count (0 = 1 beat); sampled with req_valid.
REQ-008 req_grant  output  1  one-cycle pulse: latched request accepted on the AR channel.
REQ-009 rd_valid  output  1  one-cycle strobe per forwarded data beat.
REQ-010 rd_data  output  32  beat data, valid with rd_valid.
REQ-011 m_axi_araddr/arlen/arsize/arburst/arvalid  output  32/8/3/2/1  AXI4 read address channel.
REQ-012 m_axi_arready  input  1  AXI read address ready.
REQ-013 m_axi_rdata/rresp/rlast/rvalid  input  32/2/1/1  AXI4 read data channel.
REQ-014 m_axi_rready  output  1  AXI read data ready.
REQ-015 busy  output  1  high while a request is pending, AR is valid, or any burst is outstanding.
REQ-016 err  output  1  sticky error flag.

Function
REQ-017 The block shall hold a one-entry pending register (valid, addr, len), loaded on req_valid when flush=0 and the entry is empty.
REQ-018 req_valid while the entry is full, or while arvalid is high, shall be dropped and shall set err.
REQ-019 req_valid while flush=1 shall be dropped silently.
REQ-020 The AR launch condition is: entry valid, arvalid=0, flush=0, and outstanding < MAX_OUTSTANDING.
REQ-021 When the launch condition holds, the next cycle shall drive arvalid=1 with araddr/arlen from the entry, arsize=3'b010 and arburst=2'b01 (INCR), and shall clear the entry.
REQ-022 arvalid, araddr and arlen shall remain stable until the cycle in which arvalid and arready are both high; flush shall not withdraw an asserted arvalid.
REQ-023 req_grant shall pulse for exactly one cycle, the cycle after the AR handshake.
REQ-024 Earliest accept-to-grant timing: req_valid at cycle N gives arvalid at N+2; if arready=1 then, req_grant pulses at N+3.
REQ-025 outstanding (4 bits) shall increment on the AR handshake and decrement on an R handshake with rlast=1.
REQ-026 When both events of REQ-025 occur in the same cycle, outstanding shall stay unchanged; it shall never exceed MAX_OUTSTANDING or underflow.
REQ-027 m_axi_rready shall be 1 in every cycle after reset is released; the consumer has no backpressure.
REQ-028 Forwarding: when rvalid=1 and the current burst is not discarded, rd_valid and rd_data (=rdata) shall appear registered, 1 cycle after the R handshake.
REQ-029 discard_cnt (4 bits) counts the oldest outstanding bursts whose data must be dropped.
REQ-030 While flush=1, discard_cnt shall be loaded every cycle with the next-cycle value of outstanding.
REQ-031 While flush=0 and discard_cnt>0, every beat shall be dropped (no rd_valid), and discard_cnt shall decrement on a beat with rlast=1.
REQ-032 Because AXI returns same-ID data in order, bursts issued after flush deasserts shall be forwarded only once discard_cnt reaches 0.
REQ-033 Any R beat with rresp != 2'b00 shall set err; that beat is still forwarded or discarded per REQ-028/REQ-031.
REQ-034 err shall clear only on reset.
REQ-035 busy = entry valid OR arvalid OR (outstanding != 0), registered.

Reset
REQ-036 While rst_n=0, the block shall hold: arvalid=0, araddr=0, arlen=0, rready=0, req_grant=0, rd_valid=0, rd_data=0, busy=0, err=0, entry empty, outstanding=0, discard_cnt=0.
REQ-037 Assertion of rst_n mid-burst shall abandon all state immediately; data still arriving from the slave afterwards is the system's responsibility.
REQ-038 arsize and arburst shall be held constant (3'b010, 2'b01), including during reset.

Verification
REQ-039 Single burst: req addr=0x1000, len=15, arready=1, 16 beats -> req_grant at N+3; 16 rd_valid with data identical to rdata; outstanding returns to 0; busy drops.
REQ-040 Outstanding limit: MAX=4, arready=1, no R data, 5 requests each issued after the previous grant -> 4 grants; the 5th arvalid is withheld until one rlast completes.
REQ-041 Flush mid-stream: 2 bursts outstanding, 3 beats of the first delivered, flush pulsed 1 cycle, new req 0x2000 -> remaining 29 old beats are discarded; only 0x2000 data is forwarded.
REQ-042 AR stall plus flush: arvalid held with arready=0, flush asserted -> arvalid stays high until arready; that burst's data is fully discarded.
REQ-043 Error paths: req_valid twice with arready=0 -> second request dropped and err=1; an rresp=2'b10 beat -> err stays 1 until rst_n low.
REQ-044 Simultaneous AR handshake and rlast with outstanding=2 -> outstanding stays 2; reset asserted mid-burst -> all REQ-036 values on the next sample.
